// File: rtl/clkgen_pkg.sv
// Shared types, widths and helpers for the CLKFX frequency synthesizer.
package clkgen_pkg;

    localparam int MD_W  = 8;
    localparam int ACC_W = 10;

    // Command bit following the start bit selects which shadow value is loaded.
    localparam logic CMD_LOAD_D = 1'b0;
    localparam logic CMD_LOAD_M = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_SHIFT,
        ST_WAIT_GO
    } prog_state_t;

    // M/D are stored as value-1; the ratio is illegal when 2*M exceeds D.
    function automatic logic md_illegal(input logic [MD_W-1:0] m_m1,
                                        input logic [MD_W-1:0] d_m1);
        logic [ACC_W-1:0] w_m2;
        logic [ACC_W-1:0] w_d;
        w_m2 = (ACC_W'(m_m1) + ACC_W'(1)) << 1;
        w_d  = ACC_W'(d_m1) + ACC_W'(1);
        return (w_m2 > w_d);
    endfunction

endpackage

// File: rtl/clkgen_prog_if.sv
// Serial programming port: PROGCLK synchronizer, command FSM, shadow and
// active M/D registers. Emits a one-cycle GO pulse when new values are applied.
module clkgen_prog_if
    import clkgen_pkg::*;
#(
    parameter int M_RST = 2,
    parameter int D_RST = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_freeze,
    input  logic            i_progclk,
    input  logic            i_progdata,
    input  logic            i_progen,
    output logic            o_go,
    output logic [MD_W-1:0] o_m_m1,
    output logic [MD_W-1:0] o_d_m1
);

    prog_state_t     r_state;
    prog_state_t     w_state_next;
    logic            r_pclk_s1, r_pclk_s2, r_pclk_s3;
    logic            w_edge;
    logic            w_go, w_commit, w_sel_en, w_shift_en;
    logic            r_sel;
    logic [2:0]      r_bit_cnt;
    logic [MD_W-1:0] r_shift;
    logic [MD_W-1:0] r_sh_m, r_sh_d;
    logic            r_sh_m_vld, r_sh_d_vld;
    logic [MD_W-1:0] r_act_m, r_act_d;

    assign w_edge = r_pclk_s2 & ~r_pclk_s3;

    // Two-flop synchronizer plus a delay stage for PROGCLK rising-edge detection.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pclk_s1 <= 1'b0;
            r_pclk_s2 <= 1'b0;
            r_pclk_s3 <= 1'b0;
        end else begin
            r_pclk_s1 <= i_progclk;
            r_pclk_s2 <= r_pclk_s1;
            r_pclk_s3 <= r_pclk_s2;
        end
    end

    // Programming FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state and control strobes; only detected PROGCLK edges advance the FSM.
    always_comb begin
        w_state_next = r_state;
        w_go         = 1'b0;
        w_commit     = 1'b0;
        w_sel_en     = 1'b0;
        w_shift_en   = 1'b0;
        if (w_edge) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_progen) begin
                        if (i_progdata) w_state_next = ST_CMD;
                        else            w_go = ~i_freeze;
                    end
                end
                ST_CMD: begin
                    if (i_progen) begin
                        w_sel_en     = 1'b1;
                        w_state_next = ST_SHIFT;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (i_progen) begin
                        w_shift_en = 1'b1;
                        if (r_bit_cnt == 3'd7) w_state_next = ST_WAIT_GO;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_WAIT_GO: begin
                    // The value is accepted only once PROGEN drops after bit 8.
                    w_commit     = ~i_progen;
                    w_state_next = ST_IDLE;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Shift register, shadow values and active M/D update on GO.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sel      <= CMD_LOAD_D;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_sh_m     <= '0;
            r_sh_d     <= '0;
            r_sh_m_vld <= 1'b0;
            r_sh_d_vld <= 1'b0;
            r_act_m    <= MD_W'(M_RST - 1);
            r_act_d    <= MD_W'(D_RST - 1);
        end else begin
            if (w_sel_en) begin
                r_sel     <= i_progdata;
                r_bit_cnt <= '0;
            end
            if (w_shift_en) begin
                r_shift   <= {i_progdata, r_shift[MD_W-1:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_commit) begin
                if (r_sel == CMD_LOAD_M) begin
                    r_sh_m     <= r_shift;
                    r_sh_m_vld <= 1'b1;
                end else begin
                    r_sh_d     <= r_shift;
                    r_sh_d_vld <= 1'b1;
                end
            end
            if (w_go) begin
                if (r_sh_m_vld) r_act_m <= r_sh_m;
                if (r_sh_d_vld) r_act_d <= r_sh_d;
                r_sh_m_vld <= 1'b0;
                r_sh_d_vld <= 1'b0;
            end
        end
    end

    assign o_go   = w_go;
    assign o_m_m1 = r_act_m;
    assign o_d_m1 = r_act_d;

endmodule

// File: rtl/clkgen_fx_synth.sv
// Frequency synthesizer: phase accumulator producing CLKFX = CLKIN*M/D,
// its complement, a divided CLKFXDV, and lock/PROGDONE status.
module clkgen_fx_synth
    import clkgen_pkg::*;
#(
    parameter int  CLKFX_MULTIPLY  = 2,
    parameter int  CLKFX_DIVIDE    = 8,
    parameter int  CLKFXDV_DIVIDE  = 8,
    parameter real CLKFX_MD_MAX    = 0.0,
    parameter real CLKIN_PERIOD    = 10.0,
    parameter      SPREAD_SPECTRUM = "NONE",
    parameter      STARTUP_WAIT    = "FALSE",
    parameter int  LOCK_CYCLES     = 16
) (
    input  logic       CLKIN,
    input  logic       RST,
    input  logic       FREEZEDCM,
    input  logic       PROGCLK,
    input  logic       PROGDATA,
    input  logic       PROGEN,
    output logic       CLKFX,
    output logic       CLKFX180,
    output logic       CLKFXDV,
    output logic       LOCKED,
    output logic       PROGDONE,
    output logic [1:0] STATUS
);

    localparam int LCW = $clog2(LOCK_CYCLES + 1);
    localparam int DVH = CLKFXDV_DIVIDE / 2;

    if (SPREAD_SPECTRUM != "NONE") begin : g_bad_ss
        $error("clkgen_fx_synth: only SPREAD_SPECTRUM=NONE is supported");
    end
    if (STARTUP_WAIT != "FALSE" && STARTUP_WAIT != "TRUE") begin : g_bad_sw
        $error("clkgen_fx_synth: STARTUP_WAIT must be TRUE or FALSE");
    end
    if (CLKFXDV_DIVIDE != 2 && CLKFXDV_DIVIDE != 4 && CLKFXDV_DIVIDE != 8 &&
        CLKFXDV_DIVIDE != 16 && CLKFXDV_DIVIDE != 32) begin : g_bad_dv
        $error("clkgen_fx_synth: CLKFXDV_DIVIDE must be 2, 4, 8, 16 or 32");
    end
    if (LOCK_CYCLES < 1 || CLKIN_PERIOD <= 0.0 || CLKFX_MD_MAX < 0.0) begin : g_bad_misc
        $error("clkgen_fx_synth: illegal LOCK_CYCLES, CLKIN_PERIOD or CLKFX_MD_MAX");
    end

    logic             w_go;
    logic [MD_W-1:0]  w_m_m1, w_d_m1;
    logic [ACC_W-1:0] w_step, w_d, w_sum;
    logic             w_illegal;
    logic [ACC_W-1:0] r_acc, w_acc_next;
    logic             r_fx, w_fx_next;
    logic             r_fx180, r_dv;
    logic [4:0]       r_dv_cnt;
    logic             r_locked, w_locked_next;
    logic [LCW-1:0]   r_lock_cnt, w_cnt_next;
    logic             r_progdone, w_progdone_next;

    clkgen_prog_if #(
        .M_RST (CLKFX_MULTIPLY),
        .D_RST (CLKFX_DIVIDE)
    ) u_prog (
        .i_clk      (CLKIN),
        .i_rst      (RST),
        .i_freeze   (FREEZEDCM),
        .i_progclk  (PROGCLK),
        .i_progdata (PROGDATA),
        .i_progen   (PROGEN),
        .o_go       (w_go),
        .o_m_m1     (w_m_m1),
        .o_d_m1     (w_d_m1)
    );

    assign w_step    = (ACC_W'(w_m_m1) + ACC_W'(1)) << 1;
    assign w_d       = ACC_W'(w_d_m1) + ACC_W'(1);
    assign w_sum     = r_acc + w_step;
    assign w_illegal = md_illegal(w_m_m1, w_d_m1);

    // Accumulator, lock counter and PROGDONE next state; GO overrides lock completion.
    always_comb begin
        w_acc_next      = r_acc;
        w_fx_next       = r_fx;
        w_locked_next   = r_locked;
        w_cnt_next      = r_lock_cnt;
        w_progdone_next = r_progdone;
        if (w_go) begin
            w_acc_next      = '0;
            w_fx_next       = 1'b0;
            w_locked_next   = 1'b0;
            w_cnt_next      = '0;
            w_progdone_next = 1'b0;
        end else if (!r_locked) begin
            w_acc_next = '0;
            w_fx_next  = 1'b0;
            if (w_illegal) begin
                w_cnt_next = '0;
            end else begin
                w_cnt_next = r_lock_cnt + 1'b1;
                if (r_lock_cnt == LCW'(LOCK_CYCLES - 1)) begin
                    w_locked_next   = 1'b1;
                    w_progdone_next = 1'b1;
                end
            end
        end else if (w_sum >= w_d) begin
            w_acc_next = w_sum - w_d;
            w_fx_next  = ~r_fx;
        end else begin
            w_acc_next = w_sum;
        end
    end

    // Register all outputs; CLKFXDV toggles every DVH rising edges of CLKFX.
    always_ff @(posedge CLKIN or posedge RST) begin
        if (RST) begin
            r_acc      <= '0;
            r_fx       <= 1'b0;
            r_fx180    <= 1'b0;
            r_dv       <= 1'b0;
            r_dv_cnt   <= '0;
            r_locked   <= 1'b0;
            r_lock_cnt <= '0;
            r_progdone <= 1'b1;
        end else begin
            r_acc      <= w_acc_next;
            r_fx       <= w_fx_next;
            r_fx180    <= w_locked_next & ~w_fx_next;
            r_locked   <= w_locked_next;
            r_lock_cnt <= w_cnt_next;
            r_progdone <= w_progdone_next;
            if (!w_locked_next) begin
                r_dv     <= 1'b0;
                r_dv_cnt <= '0;
            end else if (w_fx_next & ~r_fx) begin
                if (r_dv_cnt == 5'(DVH - 1)) begin
                    r_dv_cnt <= '0;
                    r_dv     <= ~r_dv;
                end else begin
                    r_dv_cnt <= r_dv_cnt + 5'd1;
                end
            end
        end
    end

    assign CLKFX    = r_fx;
    assign CLKFX180 = r_fx180;
    assign CLKFXDV  = r_dv;
    assign LOCKED   = r_locked;
    assign PROGDONE = r_progdone;
    assign STATUS   = {~r_locked & ~RST, w_illegal};

endmodule

// File: tb/tb_clkgen_fx_synth.sv
// Directed testbench for clkgen_fx_synth.
module tb_clkgen_fx_synth;

    logic       CLKIN = 1'b0;
    logic       RST, FREEZEDCM, PROGCLK, PROGDATA, PROGEN;
    logic       CLKFX, CLKFX180, CLKFXDV, LOCKED, PROGDONE;
    logic [1:0] STATUS;

    int n_tests = 0;
    int n_fail  = 0;

    clkgen_fx_synth #(
        .CLKFX_MULTIPLY (2),
        .CLKFX_DIVIDE   (8),
        .CLKFXDV_DIVIDE (8),
        .LOCK_CYCLES    (16)
    ) dut (
        .CLKIN     (CLKIN),
        .RST       (RST),
        .FREEZEDCM (FREEZEDCM),
        .PROGCLK   (PROGCLK),
        .PROGDATA  (PROGDATA),
        .PROGEN    (PROGEN),
        .CLKFX     (CLKFX),
        .CLKFX180  (CLKFX180),
        .CLKFXDV   (CLKFXDV),
        .LOCKED    (LOCKED),
        .PROGDONE  (PROGDONE),
        .STATUS    (STATUS)
    );

    always #5 CLKIN = ~CLKIN;

    // Count negedges until LOCKED is seen high; -1 on timeout.
    task automatic wait_lock(output int n);
        n = 0;
        while (LOCKED !== 1'b1 && n < 200) begin
            @(negedge CLKIN);
            n++;
        end
        if (LOCKED !== 1'b1) n = -1;
    endtask

    // Measure high/low cycle counts of CLKFX (which=0) or CLKFXDV (which=1).
    task automatic measure(input int which, output int hi, output int lo);
        int t;
        hi = -1;
        lo = -1;
        t  = 0;
        while (((which == 0) ? CLKFX : CLKFXDV) !== 1'b0 && t < 200) begin
            @(negedge CLKIN); t++;
        end
        while (((which == 0) ? CLKFX : CLKFXDV) !== 1'b1 && t < 200) begin
            @(negedge CLKIN); t++;
        end
        if (t >= 200) return;
        hi = 0;
        while (((which == 0) ? CLKFX : CLKFXDV) === 1'b1 && hi < 100) begin
            @(negedge CLKIN); hi++;
        end
        lo = 0;
        while (((which == 0) ? CLKFX : CLKFXDV) === 1'b0 && lo < 100) begin
            @(negedge CLKIN); lo++;
        end
    endtask

    task automatic prog_edge(input logic en, input logic data);
        PROGEN   = en;
        PROGDATA = data;
        repeat (2) @(negedge CLKIN);
        PROGCLK = 1'b1;
        repeat (4) @(negedge CLKIN);
        PROGCLK = 1'b0;
        repeat (2) @(negedge CLKIN);
    endtask

    task automatic prog_value(input logic sel, input int val);
        logic [7:0] v;
        v = 8'(val - 1);
        prog_edge(1'b1, 1'b1);
        prog_edge(1'b1, sel);
        for (int i = 0; i < 8; i++) prog_edge(1'b1, v[i]);
        prog_edge(1'b0, 1'b0);
    endtask

    task automatic go_cmd();
        prog_edge(1'b1, 1'b0);
        PROGEN = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLKIN);
        n_tests++; if (CLKFX !== 1'b0)    begin n_fail++; $display("FAIL rst_clkfx got %b exp 0", CLKFX); end
        n_tests++; if (CLKFX180 !== 1'b0) begin n_fail++; $display("FAIL rst_clkfx180 got %b exp 0", CLKFX180); end
        n_tests++; if (CLKFXDV !== 1'b0)  begin n_fail++; $display("FAIL rst_clkfxdv got %b exp 0", CLKFXDV); end
        n_tests++; if (LOCKED !== 1'b0)   begin n_fail++; $display("FAIL rst_locked got %b exp 0", LOCKED); end
        n_tests++; if (PROGDONE !== 1'b1) begin n_fail++; $display("FAIL rst_progdone got %b exp 1", PROGDONE); end
        n_tests++; if (STATUS !== 2'b00)  begin n_fail++; $display("FAIL rst_status got %b exp 00", STATUS); end
    endtask

    task automatic test_defaults();
        int n, hi, lo, bad;
        @(negedge CLKIN);
        RST = 1'b0;
        #1;
        n_tests++; if (STATUS !== 2'b10) begin n_fail++; $display("FAIL unlocked_status got %b exp 10", STATUS); end
        wait_lock(n);
        n_tests++; if (n !== 16) begin n_fail++; $display("FAIL lock_latency got %0d exp 16", n); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLKIN);
            if (CLKFX180 !== ~CLKFX) bad++;
        end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL clkfx180_compl got %0d bad exp 0", bad); end
        measure(0, hi, lo);
        n_tests++; if (hi !== 2 || lo !== 2) begin n_fail++; $display("FAIL fx_default got %0d/%0d exp 2/2", hi, lo); end
        measure(1, hi, lo);
        n_tests++; if (hi !== 16 || lo !== 16) begin n_fail++; $display("FAIL fxdv_default got %0d/%0d exp 16/16", hi, lo); end
    endtask

    task automatic test_async_reset();
        int t, n;
        t = 0;
        while (CLKFX !== 1'b1 && t < 50) begin @(negedge CLKIN); t++; end
        #1 RST = 1'b1;
        #1;
        n_tests++; if ({CLKFX, CLKFX180, CLKFXDV, LOCKED} !== 4'b0000) begin
            n_fail++; $display("FAIL async_rst_outs got %b exp 0000", {CLKFX, CLKFX180, CLKFXDV, LOCKED});
        end
        n_tests++; if (PROGDONE !== 1'b1) begin n_fail++; $display("FAIL async_rst_progdone got %b exp 1", PROGDONE); end
        repeat (3) @(negedge CLKIN);
        RST = 1'b0;
        wait_lock(n);
        n_tests++; if (n !== 16) begin n_fail++; $display("FAIL relock_after_rst got %0d exp 16", n); end
    endtask

    task automatic test_program_md();
        int n, hi, lo;
        prog_value(1'b0, 10);
        prog_value(1'b1, 1);
        go_cmd();
        n_tests++; if (PROGDONE !== 1'b0) begin n_fail++; $display("FAIL go_progdone_low got %b exp 0", PROGDONE); end
        n_tests++; if (LOCKED !== 1'b0)   begin n_fail++; $display("FAIL go_locked_low got %b exp 0", LOCKED); end
        wait_lock(n);
        n_tests++; if (n !== 13) begin n_fail++; $display("FAIL go_relock got %0d exp 13", n); end
        n_tests++; if (PROGDONE !== 1'b1) begin n_fail++; $display("FAIL progdone_with_lock got %b exp 1", PROGDONE); end
        measure(0, hi, lo);
        n_tests++; if (hi !== 5 || lo !== 5) begin n_fail++; $display("FAIL fx_m1_d10 got %0d/%0d exp 5/5", hi, lo); end
    endtask

    task automatic test_freeze();
        int hi, lo;
        FREEZEDCM = 1'b1;
        prog_value(1'b0, 16);
        go_cmd();
        n_tests++; if (PROGDONE !== 1'b1 || LOCKED !== 1'b1) begin
            n_fail++; $display("FAIL freeze_go got pd=%b lk=%b exp 1/1", PROGDONE, LOCKED);
        end
        repeat (20) @(negedge CLKIN);
        n_tests++; if (LOCKED !== 1'b1) begin n_fail++; $display("FAIL freeze_locked got %b exp 1", LOCKED); end
        measure(0, hi, lo);
        n_tests++; if (hi !== 5 || lo !== 5) begin n_fail++; $display("FAIL freeze_fx got %0d/%0d exp 5/5", hi, lo); end
        FREEZEDCM = 1'b0;
    endtask

    task automatic test_partial_abort();
        int n, hi, lo;
        @(negedge CLKIN);
        RST = 1'b1;
        @(negedge CLKIN);
        RST = 1'b0;
        wait_lock(n);
        prog_edge(1'b1, 1'b1);
        prog_edge(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) prog_edge(1'b1, 1'b1);
        prog_edge(1'b0, 1'b0);
        go_cmd();
        n_tests++; if (PROGDONE !== 1'b0) begin n_fail++; $display("FAIL abort_go_progdone got %b exp 0", PROGDONE); end
        wait_lock(n);
        measure(0, hi, lo);
        n_tests++; if (hi !== 2 || lo !== 2) begin n_fail++; $display("FAIL abort_fx got %0d/%0d exp 2/2", hi, lo); end
    endtask

    task automatic test_illegal();
        int bad;
        prog_value(1'b1, 5);
        go_cmd();
        n_tests++; if (STATUS[0] !== 1'b1) begin n_fail++; $display("FAIL illegal_status0 got %b exp 1", STATUS[0]); end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLKIN);
            if (LOCKED !== 1'b0 || CLKFX !== 1'b0 || CLKFX180 !== 1'b0) bad++;
        end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL illegal_held got %0d bad exp 0", bad); end
        n_tests++; if (STATUS !== 2'b11) begin n_fail++; $display("FAIL illegal_status got %b exp 11", STATUS); end
        n_tests++; if (PROGDONE !== 1'b0) begin n_fail++; $display("FAIL illegal_progdone got %b exp 0", PROGDONE); end
        RST = 1'b1;
        #1;
        n_tests++; if (STATUS !== 2'b00) begin n_fail++; $display("FAIL rst_reverts_md got %b exp 00", STATUS); end
    endtask

    initial begin
        RST       = 1'b1;
        FREEZEDCM = 1'b0;
        PROGCLK   = 1'b0;
        PROGDATA  = 1'b0;
        PROGEN    = 1'b0;
        test_reset();
        test_defaults();
        test_async_reset();
        test_program_md();
        test_freeze();
        test_partial_abort();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clkgen_fx_synth.md
Name: clkgen_fx_synth

Overview:
- Synthesizable single-clock model of a digital frequency synthesizer: derives CLKFX = CLKIN·M/D, its 180° complement, and a divided CLKFXDV, all as registered signals in the CLKIN domain.
- M/D are reprogrammable at run time through a serial PROG interface; LOCKED and PROGDONE report status.
- Sits at the top of the design and feeds pixel/system logic, e.g. 100 MHz in → 25 MHz out with M=2, D=8.

Parameters:
- CLKFX_MULTIPLY, 2, reset value of M; legal range 1..255.
- CLKFX_DIVIDE, 8, reset value of D; legal range 1..256.
- CLKFXDV_DIVIDE, 8, CLKFXDV divide ratio relative to CLKFX; legal values 2, 4, 8, 16, 32.
- CLKFX_MD_MAX, 0.0, timing-analysis hint only; no effect.
- CLKIN_PERIOD, 10.0, input period in ns; informational only.
- SPREAD_SPECTRUM, "NONE", only "NONE" is supported; any other value is an elaboration error.
- STARTUP_WAIT, "FALSE", ignored.
- LOCK_CYCLES, 16, CLKIN cycles from reset release (or GO) until LOCKED.

Ports:
- CLKIN  in  1  sole clock; all logic on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- FREEZEDCM  in  1  when high, a GO command is ignored.
- PROGCLK  in  1  programming strobe; a 0→1 edge is detected in the CLKIN domain (2-flop synchronizer, then edge detect).
- PROGDATA  in  1  serial programming data, sampled on a detected PROGCLK edge.
- PROGEN  in  1  programming enable, sampled on a detected PROGCLK edge.
- CLKFX  out  1  synthesized clock.
- CLKFX180  out  1  complement of CLKFX.
- CLKFXDV  out  1  CLKFX divided by CLKFXDV_DIVIDE.
- LOCKED  out  1  outputs valid.
- PROGDONE  out  1  high when idle or when programming is complete.
- STATUS  out  2  [0]: illegal M/D (2·M > D); [1]: CLKFX stopped (LOCKED low and RST low).

Behaviour:
- Reset state (asynchronous):
  - accumulator = 0; CLKFX = CLKFX180 = CLKFXDV = 0.
  - LOCKED = 0; PROGDONE = 1; lock counter = 0.
  - Active M/D loaded from the parameters; shadow M/D cleared; STATUS recomputed.
- Synthesis:
  - Phase accumulator width ≥ 10 bits.
  - Each CLKIN cycle while locked: acc += 2·M. If acc + 2·M ≥ D, then acc = acc + 2·M − D and CLKFX toggles.
  - Result: average frequency = fin·M/D; duty is exactly 50% when D/(2M) is an integer.
  - All outputs are registered, so they are glitch-free.
- Illegal M/D (2·M > D): STATUS[0]=1, CLKFX frozen low, LOCKED stays 0.
- CLKFX180 = ~CLKFX while LOCKED; 0 otherwise.
- CLKFXDV: counter on CLKFX rising toggles, i.e. CLKIN cycles where CLKFX goes 0→1. CLKFXDV toggles every CLKFXDV_DIVIDE/2 CLKFX rising edges.
- Lock:
  - The lock counter counts CLKIN cycles after RST deasserts.
  - LOCKED rises on the cycle the counter reaches LOCK_CYCLES.
  - While unlocked, CLKFX/CLKFX180/CLKFXDV are held 0 and the accumulator is held at 0.
- Programming FSM, evaluated only on detected PROGCLK edges; states IDLE, CMD, SHIFT, WAIT_GO:
  - IDLE → CMD: PROGEN=1 with PROGDATA=1 (start bit).
  - CMD: next bit selects the shadow target (0 = D, 1 = M).
  - SHIFT: 8 data bits, LSB first, carrying value−1.
  - Shift end: PROGEN must drop after the 8th bit. If PROGEN drops early, the partial value is discarded → IDLE.
  - GO command: a single PROGCLK edge with PROGEN=1 and PROGDATA=0 from IDLE.
  - On GO (when FREEZEDCM=0):
    - active M/D ← shadow values; values never loaded keep their current setting.
    - PROGDONE ← 0; LOCKED ← 0; lock counter restarts.
  - PROGDONE returns to 1 together with LOCKED.
  - GO while FREEZEDCM=1 is ignored; PROGDONE stays 1.
- RST mid-programming aborts the FSM → IDLE and reverts to the parameter M/D.
- Simultaneous GO and lock completion: GO wins and the counter restarts.

Decomposition:
- Package clkgen_pkg holds:
  - prog-FSM state enum;
  - command-bit constants (CMD_LOAD_D=0, CMD_LOAD_M=1);
  - widths: MD_W=8, ACC_W=10.
- One natural sub-module: clkgen_prog_if (synchronizer + serial FSM + shadow registers). The top holds the accumulator, dividers and lock logic.

Test Plan:
- Defaults (M=2, D=8), RST pulse then release:
  - LOCKED rises after 16 CLKIN cycles.
  - CLKFX period 4 CLKIN cycles, 2 high / 2 low.
  - CLKFXDV period 32 cycles.
  - CLKFX180 = ~CLKFX.
- Assert RST asynchronously while running: all outputs 0 and PROGDONE=1 within the same cycle, with no CLKIN edge needed.
- Program D=10 (bits 1,0 then 9 LSB-first), M=1 (bits 1,1 then 0), then GO:
  - PROGDONE low until relock.
  - Afterwards CLKFX period is 10 CLKIN cycles, 5 high / 5 low.
- Program M=5 with D=8 (2M>D), then GO: STATUS[0]=1, LOCKED stays 0, CLKFX held 0.
- GO with FREEZEDCM=1: M/D unchanged; PROGDONE and LOCKED stay 1; CLKFX period unchanged.
- PROGEN dropped after 4 data bits, then GO: shadow value discarded; output frequency unchanged after relock.
